uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver: 5-9 data bits, LSB first, optional parity, 1 or 2 stop bits.
//  Adds framing/parity error flags and line-stuck-low (break) recovery.
//  Sits between the board RX pin and byte-consuming logic, in the same clock domain.
// PARAMETERS
//  CLKS_PER_BIT  87  clocks per bit period; >=4; counter width $clog2(CLKS_PER_BIT)
//  DATA_BITS     8   data bits per frame, 5..9
//  STOP_BITS     1   stop bits checked, 1 or 2
//  PARITY_ODD    0   0 = even, 1 = odd parity (used only with UART_RX_PARITY_EN)
// PORTS
//  i_Clock        in   1          system clock, rising edge
//  i_Reset        in   1          asynchronous, active-high reset
//  i_Rx_Serial    in   1          asynchronous serial line, idle high
//  o_Rx_DV        out  1          one-cycle strobe: frame complete, outputs below valid
//  o_Rx_Byte      out  DATA_BITS  received data, bit0 = first bit on line
//  o_Frame_Err    out  1          stop bit sampled low; valid with o_Rx_DV
//  o_Parity_Err   out  1          parity mismatch; valid with o_Rx_DV
//  o_Busy         out  1          high in every state except IDLE
// BEHAVIOUR
//  - Reset: sync flops = 1; state IDLE; counters 0; o_Rx_DV, o_Rx_Byte, o_Frame_Err,
//    o_Parity_Err, o_Busy = 0. Takes effect mid-frame; partial frame discarded, no DV.
//  - i_Rx_Serial passes through a 2-flop synchroniser; FSM sees only the synchronised bit.
//  - States: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH.
//  - IDLE: clear counters; sync bit = 0 -> START.
//  - START: count to (CLKS_PER_BIT-1)/2; sample there. Low: clear count -> DATA.
//    High: glitch, -> IDLE, no DV.
//  - DATA: sample every CLKS_PER_BIT clocks into bit index 0..DATA_BITS-1.
//    After last bit: -> PARITY if macro defined, else -> STOP.
//  - PARITY: sample once; compute error = ^{data,parity_bit} ^ PARITY_ODD.
//  - STOP: sample every CLKS_PER_BIT clocks, STOP_BITS times. Any low sample sets frame error.
//    After the final stop sample -> DONE.
//  - DONE, one cycle: o_Rx_DV = 1; o_Rx_Byte, o_Frame_Err, o_Parity_Err updated together.
//    No frame error: -> IDLE. Frame error: -> WAIT_HIGH.
//  - WAIT_HIGH: hold until sync bit = 1, then -> IDLE.
//    A break or stuck-low line yields exactly one errored DV, not a stream of frames.
//  - o_Rx_Byte and both error flags hold their values until the next DONE.
//    o_Rx_DV is high for exactly 1 cycle per frame.
//  - Latency: DV rises 2 (sync) + 1 clocks after the mid-sample of the last stop bit.
//  - Re-arm: IDLE is re-entered mid stop bit. A start edge arriving at the nominal
//    end of stop is caught; back-to-back frames with no idle gap are received.
//  - Counter compares are exact-equality at full counter width; no wrap-around.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    PARITY state present; frame = start + DATA_BITS + parity + STOP_BITS.
//    o_Parity_Err as described above.
//  UART_RX_PARITY_EN undefined:
//    no PARITY state; frame = start + DATA_BITS + STOP_BITS.
//    o_Parity_Err tied 0; PARITY_ODD ignored.
// TESTING (CLKS_PER_BIT=8, DATA_BITS=8, STOP_BITS=1 unless noted)
//  1. Send 0xA5, 8N1 -> one DV pulse; Byte=0xA5; Frame_Err=0; Parity_Err=0; Busy drops after DV.
//  2. Frame 0x3C then 0xC3 back-to-back, no idle gap -> two DVs, bytes 0x3C then 0xC3, no errors.
//  3. Line low for 3 clocks, then high -> no DV; FSM back in IDLE; Busy high only briefly.
//  4. 0x55 with stop bit driven low, line held low for 40 bits, then high
//     -> exactly one DV with Frame_Err=1; no further DV until the line returns high.
//  5. UART_RX_PARITY_EN, PARITY_ODD=0:
//     0x07 with parity 1 -> Parity_Err=0; same byte with parity 0 -> Parity_Err=1.
//  6. DATA_BITS=5, STOP_BITS=2, send 0x13 with 2nd stop low -> Byte=5'h13, Frame_Err=1.
//     Separately, assert i_Reset mid-data -> all outputs 0 immediately, no DV.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 5-9 data bits (LSB first), 1 or 2 stop bits, framing/parity flags,
// break recovery. Optional parity stage is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Busy,
    output logic [2:0]           o_Dbg_State
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_DONE      = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_sync;
    logic [CW-1:0]        clk_cnt, clk_cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] data_sr, data_sr_n;
    logic                 ferr_acc, ferr_acc_n;
    logic                 dv_n, ferr_n, perr_n;
    logic [DATA_BITS-1:0] byte_n;
    logic                 par_err_calc;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_n;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) par_bit <= 1'b0;
        else         par_bit <= par_bit_n;
    end

    assign par_err_calc = (^{data_sr, par_bit}) ^ PARITY_ODD;
`else
    assign par_err_calc = 1'b0;
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state        <= S_IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            data_sr      <= '0;
            ferr_acc     <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Frame_Err  <= 1'b0;
            o_Parity_Err <= 1'b0;
        end else begin
            state        <= state_n;
            clk_cnt      <= clk_cnt_n;
            bit_idx      <= bit_idx_n;
            stop_idx     <= stop_idx_n;
            data_sr      <= data_sr_n;
            ferr_acc     <= ferr_acc_n;
            o_Rx_DV      <= dv_n;
            o_Rx_Byte    <= byte_n;
            o_Frame_Err  <= ferr_n;
            o_Parity_Err <= perr_n;
        end
    end

    // o_Rx_DV is a valid-only strobe with no ready: it is high exactly while the FSM sits in
    // DONE, and the consumer must take o_Rx_Byte and the error flags in that cycle.
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        data_sr_n  = data_sr;
        ferr_acc_n = ferr_acc;
        dv_n       = 1'b0;
        byte_n     = o_Rx_Byte;
        ferr_n     = o_Frame_Err;
        perr_n     = o_Parity_Err;
`ifdef UART_RX_PARITY_EN
        par_bit_n  = par_bit;
`endif
        case (state)
            S_IDLE: begin
                clk_cnt_n  = '0;
                bit_idx_n  = '0;
                stop_idx_n = 1'b0;
                ferr_acc_n = 1'b0;
                if (!rx_sync) state_n = S_START;
            end
            S_START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_n = '0;
                    state_n   = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_n = '0;
                    // Shift in from the top so the first bit on the line lands in bit 0.
                    data_sr_n = {rx_sync, data_sr[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n   = S_PARITY;
`else
                        state_n   = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_n = '0;
                    par_bit_n = rx_sync;
                    state_n   = S_STOP;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_n = '0;
                    if (stop_idx == LAST_STOP) begin
                        state_n = S_DONE;
                        dv_n    = 1'b1;
                        byte_n  = data_sr;
                        ferr_n  = ferr_acc | ~rx_sync;
                        perr_n  = par_err_calc;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                        ferr_acc_n = ferr_acc | ~rx_sync;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            S_DONE: begin
                // A low stop bit may be a break; wait for the line to recover before re-arming.
                state_n = o_Frame_Err ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (rx_sync) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign o_Busy      = (state != S_IDLE);
    assign o_Dbg_State = state;

endmodule
